// File: rtl/calendar_counter_if.sv
// Date-stage bus: clock-stage events and buttons in, BCD date and status out.
interface calendar_counter_if;
    logic       end_of_day;
    logic       tick_1Hz;
    logic       tick_day;
    logic       tick_month;
    logic       tick_year;
    logic [3:0] day_1s;
    logic [3:0] day_10s;
    logic [3:0] month_1s;
    logic [3:0] month_10s;
    logic [3:0] year_1s;
    logic [3:0] year_10s;
    logic       leap_year;
    logic       day_tick;

    // Driver side: clock stage, buttons, and the render stage reading the date.
    modport master (
        output end_of_day, tick_1Hz, tick_day, tick_month, tick_year,
        input  day_1s, day_10s, month_1s, month_10s, year_1s, year_10s,
        input  leap_year, day_tick
    );

    // Calendar side.
    modport slave (
        input  end_of_day, tick_1Hz, tick_day, tick_month, tick_year,
        output day_1s, day_10s, month_1s, month_10s, year_1s, year_10s,
        output leap_year, day_tick
    );
endinterface

// File: rtl/calendar_counter.sv
// Calendar counter: advances day/month/year at midnight (falling end_of_day)
// and lets held buttons step one field per rising tick_1Hz edge.
module calendar_counter #(
    parameter int unsigned RESET_DAY   = 1,
    parameter int unsigned RESET_MONTH = 1,
    parameter int unsigned RESET_YEAR  = 22
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    calendar_counter_if.slave cal
);
    localparam logic [4:0] RST_DAY_C   = 5'(RESET_DAY);
    localparam logic [3:0] RST_MONTH_C = 4'(RESET_MONTH);
    localparam logic [6:0] RST_YEAR_C  = 7'(RESET_YEAR);

    // Number of days in month m of year 20yy; every year divisible by 4 is leap here.
    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [6:0] y);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // Limit a day to the month length after a month/year change.
    function automatic logic [4:0] clamp_day(input logic [4:0] d, input logic [4:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    // Tens digit of a 0..99 value.
    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        logic [6:0] t;
        t = v / 7'd10;
        return t[3:0];
    endfunction

    // Ones digit of a 0..99 value.
    function automatic logic [3:0] bcd_ones(input logic [6:0] v);
        logic [6:0] t;
        t = v % 7'd10;
        return t[3:0];
    endfunction

    logic [4:0] day_q,   day_d;
    logic [3:0] month_q, month_d;
    logic [6:0] year_q,  year_d;
    logic       day_tick_q, day_tick_d;
    logic       eod_prev_q;
    logic       tick_prev_q;
    logic [2:0] sync_day_q, sync_month_q, sync_year_q;

    logic       mid_evt_s;
    logic       set_evt_s;
    logic       btn_day_s, btn_month_s, btn_year_s;
    logic [4:0] max_day_s;
    logic [3:0] set_month_s;
    logic [6:0] set_year_s;

    assign mid_evt_s   = eod_prev_q & ~cal.end_of_day;
    assign set_evt_s   = ~tick_prev_q & cal.tick_1Hz;
    assign btn_day_s   = sync_day_q[2];
    assign btn_month_s = sync_month_q[2];
    assign btn_year_s  = sync_year_q[2];

    // Compute the next date from the midnight and set events.
    always_comb begin
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        day_tick_d  = 1'b0;
        max_day_s   = days_in_month(month_q, year_q);
        set_month_s = (month_q == 4'd12) ? 4'd1 : (month_q + 4'd1);
        set_year_s  = (year_q == 7'd99) ? 7'd0 : (year_q + 7'd1);
        if (mid_evt_s) begin
            // Midnight wins over a coincident set event.
            day_tick_d = 1'b1;
            if (day_q < max_day_s) begin
                day_d = day_q + 5'd1;
            end else begin
                day_d = 5'd1;
                if (month_q == 4'd12) begin
                    month_d = 4'd1;
                    year_d  = set_year_s;
                end else begin
                    month_d = month_q + 4'd1;
                end
            end
        end else if (set_evt_s) begin
            if (btn_day_s) begin
                day_d = (day_q == max_day_s) ? 5'd1 : (day_q + 5'd1);
            end else if (btn_month_s) begin
                month_d = set_month_s;
                day_d   = clamp_day(day_q, days_in_month(set_month_s, year_q));
            end else if (btn_year_s) begin
                year_d = set_year_s;
                day_d  = clamp_day(day_q, days_in_month(month_q, set_year_s));
            end else begin
                day_d = day_q;
            end
        end else begin
            day_tick_d = 1'b0;
        end
    end

    // Date registers and the midnight pulse.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            day_q      <= RST_DAY_C;
            month_q    <= RST_MONTH_C;
            year_q     <= RST_YEAR_C;
            day_tick_q <= 1'b0;
        end else begin
            day_q      <= day_d;
            month_q    <= month_d;
            year_q     <= year_d;
            day_tick_q <= day_tick_d;
        end
    end

    // Edge history; loading live values in reset suppresses a false edge on release.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            eod_prev_q  <= cal.end_of_day;
            tick_prev_q <= cal.tick_1Hz;
        end else begin
            eod_prev_q  <= cal.end_of_day;
            tick_prev_q <= cal.tick_1Hz;
        end
    end

    // Three-flop button synchronizers; cleared in reset so a held button waits for refill.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            sync_day_q   <= 3'b000;
            sync_month_q <= 3'b000;
            sync_year_q  <= 3'b000;
        end else begin
            sync_day_q   <= {sync_day_q[1:0],   cal.tick_day};
            sync_month_q <= {sync_month_q[1:0], cal.tick_month};
            sync_year_q  <= {sync_year_q[1:0],  cal.tick_year};
        end
    end

    assign cal.day_1s    = bcd_ones({2'b00, day_q});
    assign cal.day_10s   = bcd_tens({2'b00, day_q});
    assign cal.month_1s  = bcd_ones({3'b000, month_q});
    assign cal.month_10s = bcd_tens({3'b000, month_q});
    assign cal.year_1s   = bcd_ones(year_q);
    assign cal.year_10s  = bcd_tens(year_q);
    assign cal.leap_year = (year_q[1:0] == 2'b00);
    assign cal.day_tick  = day_tick_q;
endmodule
